vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator with a configurable pixel-fetch lead.
- Produces hs/vs/de/rgb for any resolution and sync polarity.
- Issues pixel requests REQ_LAT cycles ahead of display, so a registered frame buffer or pattern source can answer in time.
- Sits between the pixel source (RAM/ROM/renderer) and the DAC/HDMI encoder; the next-generation display driver for all video designs.

Parameters:
- H_SYNC, 96, hsync width in clocks
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- DATA_W, 24, pixel width; must be divisible by 3
- REQ_LAT, 1, pixel source read latency in clocks, legal range 1..4
- CNT_W, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, reset, asynchronous, active-low
- en, in, 1, timing enable, synchronous
- pixel_data, in, DATA_W, pixel value, valid exactly REQ_LAT clocks after the matching pixel_req
- pixel_req, out, 1, pixel request (combinational from counters)
- pixel_x, out, CNT_W, requested column; 0 when pixel_req=0
- pixel_y, out, CNT_W, requested row; 0 when pixel_req=0
- hs, out, 1, horizontal sync (registered)
- vs, out, 1, vertical sync (registered)
- de, out, 1, data enable (registered)
- rgb, out, DATA_W, pixel out (registered); 0 when de=0
- frame_start, out, 1, one-clock pulse aligned with output h=0,v=0

Behaviour:
- Derived values: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
- Line order: sync, back porch, display, front porch. The same order applies vertically.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only on the h_cnt wrap cycle and wraps to 0 after V_TOTAL-1. The frame wrap is the cycle where both counters are at their last value.
- Raw active = h_cnt in [HA, HA+H_DISP) and v_cnt in [VA, VA+V_DISP).
- pixel_req = raw active and en.
- pixel_x = h_cnt-HA and pixel_y = v_cnt-VA while pixel_req=1; otherwise both are 0.
- Raw sync: hs_raw is active for h_cnt < H_SYNC; vs_raw is active for v_cnt < V_SYNC. The active level is set by HS_POL/VS_POL.
- Alignment: raw hs/vs/active/frame-start pass through a REQ_LAT-deep delay line.
- On the next clock edge, output registers capture the delayed controls together with pixel_data, gated to 0 when the delayed active is 0.
- Result: hs, vs, de, rgb and frame_start all lag the counters by exactly REQ_LAT+1 clocks and are mutually aligned.
- Reset (rst=0): counters = 0; delay line and outputs go inactive.
  - hs = ~HS_POL, vs = ~VS_POL.
  - de = 0, rgb = 0, frame_start = 0.
  - Reset mid-frame takes effect immediately; the asynchronous reset applies to all of these registers.
- en=0: counters are synchronously cleared to 0 and held.
  - The delay line is flushed to inactive values; outputs go inactive one clock later.
  - pixel_req = 0.
- en rising: the frame starts at h=0, v=0; frame_start pulses REQ_LAT+1 clocks later.
- Blanking: pixel_data is ignored outside the delayed active window.
- Widths: all comparisons are done in CNT_W bits. An out-of-range REQ_LAT or CNT_W is an elaboration error.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_on (1 bit).
  - While pattern_on=1: pixel_req is forced to 0, and rgb is taken from an internal 8-bar generator instead of pixel_data.
  - Bar index = pixel_x*8/H_DISP, computed from the delayed coordinate so it aligns with de.
  - Bar colours: white, yellow, cyan, green, magenta, red, blue, black. Each channel is DATA_W/3 bits, all-ones or zero.
  - Sync/de timing is unchanged.
- When undefined: port absent; rgb always comes from pixel_data.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default timing constants
  - sync polarity constants
  - bar colour table
  - function computing H_TOTAL/V_TOTAL
- One sub-module, vga_delay_line: parameters WIDTH, DEPTH, RESET_VAL; async active-low reset; synchronous flush input. Used for the hs/vs/active/frame-start pipeline.

Test Plan:
- Defaults, en=1 after reset -> hs low for 96 of every 800 clocks; vs low for 1600 of every 420000 clocks; first pixel_req at h_cnt=144, v_cnt=35 with pixel_x=0, pixel_y=0.
- REQ_LAT=3, pixel_data driven as a delayed echo of {pixel_y,pixel_x} -> rgb equals the matching coordinate; de asserts exactly 4 clocks after pixel_req; 640 de clocks per line, 480 active lines.
- HS_POL=1, VS_POL=1 -> hs high for 96 clocks per line; reset values hs=0, vs=0.
- en dropped mid-line (h_cnt=300, v_cnt=100), then raised -> outputs inactive within 1 clock of the flush; restart at h=0, v=0; frame_start pulses REQ_LAT+1 clocks after en rises.
- rst asserted mid-active-line -> de=0, rgb=0, frame_start=0 immediately; after release, hs/vs timing restarts from counter 0.
- VGA_TEST_PATTERN_EN, pattern_on=1 -> pixel_req stays 0; rgb=0xFFFFFF at x=0..79, 0xFFFF00 at x=80, 0x000000 at x=560..639.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, sync polarity values and the colour-bar table for the raster timing generator.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_FRONT = 10;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  function automatic int timing_total(input int sync, input int back, input int disp,
                                      input int front);
    return sync + back + disp + front;
  endfunction

  // {r,g,b} on/off per bar, left to right
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] rgb_bits;
    case (idx)
      3'd0:    rgb_bits = 3'b111;
      3'd1:    rgb_bits = 3'b110;
      3'd2:    rgb_bits = 3'b011;
      3'd3:    rgb_bits = 3'b010;
      3'd4:    rgb_bits = 3'b101;
      3'd5:    rgb_bits = 3'b100;
      3'd6:    rgb_bits = 3'b001;
      default: rgb_bits = 3'b000;
    endcase
    return rgb_bits;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that realigns raster controls with the pixel source latency.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, early pixel requests, REQ_LAT-deep control pipeline, registered video.
// Define VGA_TEST_PATTERN_EN to add the pattern_on input and the internal 8-bar colour source.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int H_DISP  = VGA_H_DISP,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int V_DISP  = VGA_V_DISP,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter bit HS_POL  = POL_ACTIVE_LOW,
  parameter bit VS_POL  = POL_ACTIVE_LOW,
  parameter int DATA_W  = 24,
  parameter int REQ_LAT = 1,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_on,
`endif
  input  logic [DATA_W-1:0] pixel_data,
  output logic              pixel_req,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = timing_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = timing_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

  if (REQ_LAT < 1 || REQ_LAT > 4) begin : g_bad_req_lat
    $error("vga_timing_gen: REQ_LAT must lie within 1..4");
  end
  if (CNT_W < 2 || CNT_W > 30 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end
  if (DATA_W < 3 || (DATA_W % 3) != 0) begin : g_bad_data_w
    $error("vga_timing_gen: DATA_W must be a positive multiple of 3");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] HE     = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VE     = CNT_W'(V_SYNC + V_BACK + V_DISP);

  localparam logic [3:0] CTRL_IDLE = {~HS_POL, ~VS_POL, 2'b00};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             raw_active;
  logic             hs_raw;
  logic             vs_raw;
  logic             fs_raw;
  logic             req_int;
  logic             d_hs;
  logic             d_vs;
  logic             d_act;
  logic             d_fs;
  logic [DATA_W-1:0] src_pixel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign raw_active = (h_cnt >= HA) && (h_cnt < HE) && (v_cnt >= VA) && (v_cnt < VE);
  assign hs_raw     = (h_cnt < HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw     = (v_cnt < VS_END) ? VS_POL : ~VS_POL;
  assign fs_raw     = en && (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
  localparam int               CH_W      = DATA_W / 3;
  localparam int               DL_W      = 4 + CNT_W;
  localparam logic [DL_W-1:0]  DL_RESET  = {CTRL_IDLE, {CNT_W{1'b0}}};
  localparam logic [CNT_W+2:0] H_DISP_WD = (CNT_W+3)'(H_DISP);

  logic [CNT_W-1:0] x_raw;
  logic [CNT_W-1:0] d_x;
  logic [2:0]       bar_idx;
  logic [2:0]       bar_bits;
  logic [DL_W-1:0]  dl_in;
  logic [DL_W-1:0]  dl_out;

  // the bar source needs the column even while requests are suppressed, so x is taken ungated
  assign x_raw   = raw_active ? h_cnt - HA : '0;
  assign req_int = raw_active && en && !pattern_on;
  assign dl_in   = {hs_raw, vs_raw, raw_active, fs_raw, x_raw};
  assign {d_hs, d_vs, d_act, d_fs, d_x} = dl_out;

  assign bar_idx   = 3'({d_x, 3'b000} / H_DISP_WD);
  assign bar_bits  = bar_colour(bar_idx);
  assign src_pixel = pattern_on ? {{CH_W{bar_bits[2]}}, {CH_W{bar_bits[1]}}, {CH_W{bar_bits[0]}}}
                                : pixel_data;
`else
  localparam int              DL_W     = 4;
  localparam logic [DL_W-1:0] DL_RESET = CTRL_IDLE;

  logic [DL_W-1:0] dl_in;
  logic [DL_W-1:0] dl_out;

  assign req_int   = raw_active && en;
  assign dl_in     = {hs_raw, vs_raw, raw_active, fs_raw};
  assign {d_hs, d_vs, d_act, d_fs} = dl_out;
  assign src_pixel = pixel_data;
`endif

  assign pixel_req = req_int;
  assign pixel_x   = req_int ? h_cnt - HA : '0;
  assign pixel_y   = req_int ? v_cnt - VA : '0;

  // flushing on !en means the outputs fall idle one clock after the counters are cleared
  vga_delay_line #(
    .WIDTH    (DL_W),
    .DEPTH    (REQ_LAT),
    .RESET_VAL(DL_RESET)
  ) u_ctrl_dly (
    .clk  (clk),
    .rst  (rst),
    .flush(!en),
    .din  (dl_in),
    .dout (dl_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= d_hs;
      vs          <= d_vs;
      de          <= d_act;
      rgb         <= d_act ? src_pixel : '0;
      frame_start <= d_fs;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-raster instances for pipeline/polarity/enable/reset, default 640x480 for real timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // instance A: 25x9 raster, REQ_LAT=3, active-low syncs
  localparam int A_HT    = 25;
  localparam int A_HA    = 7;
  localparam int A_HD    = 16;
  localparam int A_VA    = 4;
  localparam int A_VD    = 4;
  localparam int A_FRAME = 225;
  localparam int A_LAT   = 3;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, en_b, en_c;
  logic pat_a;

  int n_cmp = 0;
  int n_err = 0;

  logic        a_req, a_hs, a_vs, a_de, a_fs;
  logic [7:0]  a_x, a_y;
  logic [23:0] a_rgb, a_pd;
  logic [23:0] echo [3];

  logic        b_req, b_hs, b_vs, b_de, b_fs;
  logic [10:0] b_x, b_y;
  logic [23:0] b_rgb, b_pd;

  logic        c_req, c_hs, c_vs, c_de, c_fs;
  logic [7:0]  c_x, c_y;
  logic [23:0] c_rgb, c_pd;

  // pixel source model for A: returns {y,x} exactly REQ_LAT clocks after the request
  always @(posedge clk) begin
    echo[0] <= {8'h00, a_y, a_x};
    echo[1] <= echo[0];
    echo[2] <= echo[1];
  end
  assign a_pd = echo[2];

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(24), .REQ_LAT(3), .CNT_W(8)
  ) u_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en_a),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_on (pat_a),
`endif
    .pixel_data (a_pd),
    .pixel_req  (a_req),
    .pixel_x    (a_x),
    .pixel_y    (a_y),
    .hs         (a_hs),
    .vs         (a_vs),
    .de         (a_de),
    .rgb        (a_rgb),
    .frame_start(a_fs)
  );

  vga_timing_gen u_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en_b),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_on (1'b0),
`endif
    .pixel_data (b_pd),
    .pixel_req  (b_req),
    .pixel_x    (b_x),
    .pixel_y    (b_y),
    .hs         (b_hs),
    .vs         (b_vs),
    .de         (b_de),
    .rgb        (b_rgb),
    .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(24), .REQ_LAT(1), .CNT_W(8)
  ) u_c (
    .clk        (clk),
    .rst        (rst),
    .en         (en_c),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_on (1'b0),
`endif
    .pixel_data (c_pd),
    .pixel_req  (c_req),
    .pixel_x    (c_x),
    .pixel_y    (c_y),
    .hs         (c_hs),
    .vs         (c_vs),
    .de         (c_de),
    .rgb        (c_rgb),
    .frame_start(c_fs)
  );

  // Runs A from counter 0 for 'cycles' samples; outputs expected at position n-(REQ_LAT+1).
  task automatic run_a(input int cycles, output int de_cnt);
    int p, h, v, q, qh, qv;
    logic e_req, e_hs, e_vs, e_de, e_fs, q_act;
    logic [7:0] e_x, e_y;
    logic [23:0] e_rgb;
    de_cnt = 0;
    en_a = 1'b1;
    #1;
    for (int n = 0; n < cycles; n++) begin
      p = n % A_FRAME;
      h = p % A_HT;
      v = p / A_HT;
      e_req = !pat_a && h >= A_HA && h < A_HA + A_HD && v >= A_VA && v < A_VA + A_VD;
      e_x = e_req ? 8'(h - A_HA) : 8'd0;
      e_y = e_req ? 8'(v - A_VA) : 8'd0;
      q = n - (A_LAT + 1);
      if (q < 0) begin
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      end else begin
        q = q % A_FRAME;
        qh = q % A_HT;
        qv = q / A_HT;
        q_act = qh >= A_HA && qh < A_HA + A_HD && qv >= A_VA && qv < A_VA + A_VD;
        e_hs = !(qh < 4);
        e_vs = !(qv < 2);
        e_de = q_act;
        e_fs = (q == 0);
        if (!q_act) e_rgb = 24'h0;
        else if (pat_a) e_rgb = BARS[(qh - A_HA) / 2];
        else e_rgb = {8'h00, 8'(qv - A_VA), 8'(qh - A_HA)};
      end
      n_cmp++;
      if ({a_req, a_x, a_y} !== {e_req, e_x, e_y}) begin
        n_err++;
        $display("FAIL a_request n=%0d: got req=%b x=%0d y=%0d, want req=%b x=%0d y=%0d",
                 n, a_req, a_x, a_y, e_req, e_x, e_y);
      end
      n_cmp++;
      if ({a_hs, a_vs, a_de, a_fs, a_rgb} !== {e_hs, e_vs, e_de, e_fs, e_rgb}) begin
        n_err++;
        $display("FAIL a_video n=%0d: got hs=%b vs=%b de=%b fs=%b rgb=%h, want hs=%b vs=%b de=%b fs=%b rgb=%h",
                 n, a_hs, a_vs, a_de, a_fs, a_rgb, e_hs, e_vs, e_de, e_fs, e_rgb);
      end
      if (a_de === 1'b1) de_cnt++;
      if (n != cycles - 1) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_a();
    en_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; pat_a = 1'b0;
    b_pd = 24'h123456; c_pd = 24'hABCDEF;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({a_req, a_hs, a_vs, a_de, a_fs, a_rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL reset_a: got req=%b hs=%b vs=%b de=%b fs=%b rgb=%h, want 0 1 1 0 0 000000",
               a_req, a_hs, a_vs, a_de, a_fs, a_rgb);
    end
    n_cmp++;
    if ({b_req, b_hs, b_vs, b_de, b_fs, b_rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL reset_b: got req=%b hs=%b vs=%b de=%b fs=%b rgb=%h, want 0 1 1 0 0 000000",
               b_req, b_hs, b_vs, b_de, b_fs, b_rgb);
    end
    n_cmp++;
    if ({c_req, c_hs, c_vs, c_de, c_fs, c_rgb} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL reset_c_pol: got req=%b hs=%b vs=%b de=%b fs=%b rgb=%h, want 0 0 0 0 0 000000",
               c_req, c_hs, c_vs, c_de, c_fs, c_rgb);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_timing();
    int first, hs_low, vs_low;
    logic [10:0] fx, fy;
    first = -1; hs_low = 0; vs_low = 0; fx = '1; fy = '1;
    en_b = 1'b1;
    #1;
    for (int n = 0; n < 30000; n++) begin
      if (n >= 2 && n < 802 && b_hs === 1'b0) hs_low++;
      if (n >= 2 && n < 3702 && b_vs === 1'b0) vs_low++;
      if (b_req === 1'b1) begin
        first = n; fx = b_x; fy = b_y;
        break;
      end
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (first != 28144) begin
      n_err++;
      $display("FAIL b_first_req: got cycle %0d, want 28144 (h=144 v=35)", first);
    end
    n_cmp++;
    if (fx !== 11'd0 || fy !== 11'd0) begin
      n_err++;
      $display("FAIL b_first_xy: got x=%0d y=%0d, want 0 0", fx, fy);
    end
    n_cmp++;
    if (hs_low != 96) begin
      n_err++;
      $display("FAIL b_hs_width: got %0d low clocks per line, want 96", hs_low);
    end
    n_cmp++;
    if (vs_low != 1600) begin
      n_err++;
      $display("FAIL b_vs_width: got %0d low clocks, want 1600", vs_low);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({b_req, b_x, b_y} !== {1'b1, 11'd1, 11'd0}) begin
      n_err++;
      $display("FAIL b_second_req: got req=%b x=%0d y=%0d, want 1 1 0", b_req, b_x, b_y);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({b_de, b_rgb} !== {1'b1, 24'h123456}) begin
      n_err++;
      $display("FAIL b_first_de: got de=%b rgb=%h, want 1 123456", b_de, b_rgb);
    end
    en_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_polarity();
    int hs_hi, vs_hi, de_cnt, bad_rgb;
    logic fs2, hs2;
    hs_hi = 0; vs_hi = 0; de_cnt = 0; bad_rgb = 0; fs2 = 1'b0; hs2 = 1'b0;
    en_c = 1'b1;
    #1;
    for (int n = 0; n < 227; n++) begin
      if (n >= 2 && n < 27 && c_hs === 1'b1) hs_hi++;
      if (n >= 2 && c_vs === 1'b1) vs_hi++;
      if (n >= 2 && c_de === 1'b1) de_cnt++;
      if ((c_de === 1'b1 && c_rgb !== 24'hABCDEF) || (c_de !== 1'b1 && c_rgb !== 24'h0)) bad_rgb++;
      if (n == 2) begin
        fs2 = c_fs; hs2 = c_hs;
      end
      if (n != 226) begin
        @(negedge clk);
        #1;
      end
    end
    n_cmp++;
    if (hs_hi != 4) begin
      n_err++;
      $display("FAIL c_hs_high_width: got %0d, want 4", hs_hi);
    end
    n_cmp++;
    if (vs_hi != 50) begin
      n_err++;
      $display("FAIL c_vs_high_width: got %0d, want 50", vs_hi);
    end
    n_cmp++;
    if (de_cnt != 64) begin
      n_err++;
      $display("FAIL c_de_per_frame: got %0d, want 64", de_cnt);
    end
    n_cmp++;
    if (bad_rgb != 0) begin
      n_err++;
      $display("FAIL c_rgb_gating: got %0d bad clocks, want 0", bad_rgb);
    end
    n_cmp++;
    if ({fs2, hs2} !== 2'b11) begin
      n_err++;
      $display("FAIL c_frame_start_lag: got fs=%b hs=%b at 2 clocks, want 1 1", fs2, hs2);
    end
    en_c = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pipeline();
    int de_cnt;
    run_a(2 * A_FRAME + 10, de_cnt);
    n_cmp++;
    if (de_cnt != 128) begin
      n_err++;
      $display("FAIL a_de_two_frames: got %0d, want 128", de_cnt);
    end
    idle_a();
  endtask

  task automatic test_en_drop();
    int de_cnt;
    run_a(136, de_cnt);   // last sample at h=10, v=5
    en_a = 1'b0;
    #1;
    n_cmp++;
    if ({a_req, a_x, a_y} !== {1'b0, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL en_drop_req: got req=%b x=%0d y=%0d, want 0 0 0", a_req, a_x, a_y);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({a_de, a_rgb} !== {1'b1, 24'h000100}) begin
      n_err++;
      $display("FAIL en_drop_tail: got de=%b rgb=%h, want 1 000100", a_de, a_rgb);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({a_hs, a_vs, a_de, a_fs, a_rgb} !== {1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL en_drop_idle: got hs=%b vs=%b de=%b fs=%b rgb=%h, want 1 1 0 0 000000",
               a_hs, a_vs, a_de, a_fs, a_rgb);
    end
    repeat (2) @(negedge clk);
    run_a(A_FRAME + 10, de_cnt);
    n_cmp++;
    if (de_cnt != 64) begin
      n_err++;
      $display("FAIL en_restart_de: got %0d, want 64", de_cnt);
    end
    idle_a();
  endtask

  task automatic test_reset_mid_line();
    int de_cnt;
    run_a(140, de_cnt);   // de high at this point
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_req, a_hs, a_vs, a_de, a_fs, a_rgb} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
      n_err++;
      $display("FAIL reset_mid_line: got req=%b hs=%b vs=%b de=%b fs=%b rgb=%h, want 0 1 1 0 0 000000",
               a_req, a_hs, a_vs, a_de, a_fs, a_rgb);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_a(60, de_cnt);
    idle_a();
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int de_cnt;
    pat_a = 1'b1;
    run_a(A_FRAME + 10, de_cnt);
    n_cmp++;
    if (de_cnt != 64) begin
      n_err++;
      $display("FAIL pattern_de: got %0d, want 64", de_cnt);
    end
    pat_a = 1'b0;
    idle_a();
  endtask
`endif

  initial begin
    test_reset();
    test_default_timing();
    test_polarity();
    test_pipeline();
    test_en_drop();
    test_reset_mid_line();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation time limit, want summary before it");
    $fatal(1, "time limit");
  end

endmodule
